// File: rtl/store_queue.sv
// MEM-stage store queue: replicates store data across byte lanes, raises AdES on
// misaligned stores, buffers legal stores and drains them to the data-memory port.
module store_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_data,
    input  logic [1:0]                req_size,
    output logic                      exc_ades,
    output logic [ADDR_W-1:0]         exc_badvaddr,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [DATA_W/8-1:0]       mem_wstrb,
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      ld_hit,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LANES - 1);

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_DWORD = 2'b11
    } storeSize_e;

    storeSize_e         size;
    logic [OFF_W-1:0]   off;
    logic               legal;
    logic [DATA_W-1:0]  replData;
    logic [LANES-1:0]   strobe;

    logic [ADDR_W-1:0]  addrMem [DEPTH];
    logic [DATA_W-1:0]  dataMem [DEPTH];
    logic [LANES-1:0]   strbMem [DEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;

    logic full;
    logic accept;
    logic enq;
    logic deq;

    assign size = storeSize_e'(req_size);
    assign off  = req_addr[OFF_W-1:0];

    always_comb begin
        legal    = 1'b0;
        replData = '0;
        strobe   = '0;
        case (size)
            SIZE_BYTE: begin
                legal    = 1'b1;
                replData = {LANES{req_data[7:0]}};
                strobe   = LANES'(1) << off;
            end
            SIZE_HALF: begin
                legal    = !off[0];
                replData = {(LANES/2){req_data[15:0]}};
                strobe   = LANES'(2'b11) << off;
            end
            SIZE_WORD: begin
                legal    = (off[1:0] == 2'b00);
                replData = {(LANES/4){req_data[31:0]}};
                strobe   = LANES'(4'hF) << off;
            end
            SIZE_DWORD: begin
                legal    = (DATA_W == 64) && (off == '0);
                replData = req_data;
                strobe   = '1;
            end
            default: ;
        endcase
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign mem_valid = !empty;
    assign accept    = req_valid && req_ready;
    assign enq       = accept && legal;
    assign deq       = mem_valid && mem_ready;

    // The head slot is never rewritten while occupied, so a stalled beat stays stable.
    assign mem_addr  = addrMem[rdPtr];
    assign mem_wdata = dataMem[rdPtr];
    assign mem_wstrb = strbMem[rdPtr];

    always_ff @(posedge clk) begin
        if (enq) begin
            addrMem[wrPtr] <= req_addr & ALIGN_MASK;
            dataMem[wrPtr] <= replData;
            strbMem[wrPtr] <= strobe;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            exc_ades     <= 1'b0;
            exc_badvaddr <= '0;
        end else begin
            if (enq) wrPtr <= wrPtr + PTR_W'(1);
            if (deq) rdPtr <= rdPtr + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);
            exc_ades <= accept && !legal;
            if (accept && !legal) exc_badvaddr <= req_addr;
        end
    end

    // Slot i is occupied when its distance from the head is below the occupancy.
    always_comb begin
        ld_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - rdPtr)) < count) &&
                (addrMem[i] == (ld_addr & ALIGN_MASK)))
                ld_hit = 1'b1;
        end
    end
endmodule
